// File: rtl/p5_pkg.sv
// Shared definitions for the five-stage pipeline: widths, ALU ops, forwarding selects.
package p5_pkg;

    localparam int unsigned P5_DW = 32;
    localparam int unsigned P5_RW = 5;
    localparam int unsigned ALU_W = 3;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'b011;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Control half of the ID/EX register; all-zero is a bubble (add, writes $0, invalid).
    typedef struct packed {
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             reg_write;
        logic             mem_write;
        logic             mem_to_reg;
        logic             valid;
    } idex_ctrl_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Resolves one EX operand against the EX/MEM and MEM/WB producers; EX/MEM wins, $0 never forwards.
module fwd_mux
    import p5_pkg::*;
#(
    parameter int unsigned DW = P5_DW,
    parameter int unsigned RW = P5_RW
) (
    input  logic [RW-1:0] reg_num,
    input  logic [DW-1:0] reg_data,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_wa,
    input  logic [DW-1:0] mem_wd,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    output logic [DW-1:0] fwd_data
);

    fwd_sel_e sel;

    // Pick the youngest producer writing this register.
    always_comb begin
        sel = FWD_NONE;
        if (reg_num != RW'(0)) begin
            if (mem_reg_write && (mem_wa == reg_num)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_wa == reg_num)) begin
                sel = FWD_WB;
            end
        end
    end

    // Operand data mux.
    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_MEM: fwd_data = mem_wd;
            FWD_WB:  fwd_data = wb_wd;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding, immediate select and load-use bubble.
module ex_operand_stage
    import p5_pkg::*;
#(
    parameter int unsigned DW = P5_DW,
    parameter int unsigned RW = P5_RW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [DW-1:0]    id_imm,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_wa,
    input  logic [ALU_W-1:0] id_alu_ctrl,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [RW-1:0]    mem_wa,
    input  logic [DW-1:0]    mem_wd,
    input  logic             wb_reg_write,
    input  logic [RW-1:0]    wb_wa,
    input  logic [DW-1:0]    wb_wd,
    output logic             stall_req,
    output logic [DW-1:0]    src_a,
    output logic [DW-1:0]    src_b,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic [DW-1:0]    ex_store_data,
    output logic [RW-1:0]    ex_wa,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic [DW-1:0]    ex_pc,
    output logic             ex_valid
);

    logic [DW-1:0] pc_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [RW-1:0] wa_q;
    idex_ctrl_t    ctrl_q;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        stall_req = ctrl_q.mem_to_reg && ctrl_q.valid && (wa_q != RW'(0)) &&
                    ((wa_q == id_rs) || (wa_q == id_rt));
    end

    // ID/EX register; flush and load-use both collapse to a single bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wa_q      <= '0;
            ctrl_q    <= '0;
        end else if (flush || stall_req) begin
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wa_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            pc_q                <= id_pc;
            rs_data_q           <= id_rs_data;
            rt_data_q           <= id_rt_data;
            imm_q               <= id_imm;
            rs_q                <= id_rs;
            rt_q                <= id_rt;
            wa_q                <= id_wa;
            ctrl_q.alu_ctrl     <= id_alu_ctrl;
            ctrl_q.alu_src      <= id_alu_src;
            ctrl_q.reg_write    <= id_reg_write;
            ctrl_q.mem_write    <= id_mem_write;
            ctrl_q.mem_to_reg   <= id_mem_to_reg;
            ctrl_q.valid        <= 1'b1;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .reg_num       (rs_q),
        .reg_data      (rs_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_wa        (mem_wa),
        .mem_wd        (mem_wd),
        .wb_reg_write  (wb_reg_write),
        .wb_wa         (wb_wa),
        .wb_wd         (wb_wd),
        .fwd_data      (fwd_a)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .reg_num       (rt_q),
        .reg_data      (rt_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_wa        (mem_wa),
        .mem_wd        (mem_wd),
        .wb_reg_write  (wb_reg_write),
        .wb_wa         (wb_wa),
        .wb_wd         (wb_wd),
        .fwd_data      (fwd_b)
    );

    // ALU operands straight from forwarded data; SrcB may take the immediate instead.
    always_comb begin
        src_a         = fwd_a;
        ex_store_data = fwd_b;
        src_b         = ctrl_q.alu_src ? imm_q : fwd_b;
    end

    assign alu_ctrl      = ctrl_q.alu_ctrl;
    assign ex_wa         = wa_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_pc         = pc_q;
    assign ex_valid      = ctrl_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed check of ex_operand_stage against a behavioural model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        wb_reg_write;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        stall_req;
    logic [31:0] src_a, src_b, ex_store_data, ex_pc;
    logic [2:0]  alu_ctrl;
    logic [4:0]  ex_wa;
    logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_valid;

    int checks = 0;
    int errors = 0;

    // Model of the instruction currently sitting in EX.
    typedef struct {
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, wa;
        logic [2:0]  alu_ctrl;
        logic        alu_src, reg_write, mem_write, mem_to_reg, valid;
    } instr_t;

    instr_t m;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_reg_write(wb_reg_write), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .stall_req(stall_req), .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_wa(ex_wa), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_pc(ex_pc),
        .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    function automatic instr_t bubble();
        instr_t b;
        b.pc = 0; b.rs_data = 0; b.rt_data = 0; b.imm = 0;
        b.rs = 0; b.rt = 0; b.wa = 0; b.alu_ctrl = 0;
        b.alu_src = 0; b.reg_write = 0; b.mem_write = 0; b.mem_to_reg = 0; b.valid = 0;
        return b;
    endfunction

    // Value an instruction in EX reads for register r, given what is being written back.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (mem_reg_write && mem_wa == r) return mem_wd;
        if (wb_reg_write && wb_wa == r) return wb_wd;
        return d;
    endfunction

    function automatic logic model_stall();
        return m.valid && m.mem_to_reg && m.wa != 0 && (m.wa == id_rs || m.wa == id_rt);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] b;
        b = operand(m.rt, m.rt_data);
        chk("stall_req", 32'(stall_req), 32'(model_stall()));
        chk("src_a", src_a, operand(m.rs, m.rs_data));
        chk("src_b", src_b, m.alu_src ? m.imm : b);
        chk("store_data", ex_store_data, b);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m.alu_ctrl));
        chk("ex_wa", 32'(ex_wa), 32'(m.wa));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mem_write));
        chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.mem_to_reg));
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    endtask

    // Advance one clock: the model takes the ID instruction unless flushed or stalled.
    task automatic tick();
        logic take;
        take = !(flush || model_stall());
        @(posedge clk);
        if (take) begin
            m.pc = id_pc; m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.wa = id_wa; m.alu_ctrl = id_alu_ctrl;
            m.alu_src = id_alu_src; m.reg_write = id_reg_write; m.mem_write = id_mem_write;
            m.mem_to_reg = id_mem_to_reg; m.valid = 1'b1;
        end else begin
            m = bubble();
        end
        @(negedge clk);
    endtask

    task automatic quiet_fwd();
        mem_reg_write = 0; mem_wa = 0; mem_wd = 0;
        wb_reg_write = 0; wb_wa = 0; wb_wd = 0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wa, input logic [2:0] op, input logic asrc,
                          input logic load);
        id_pc = pc; id_rs = rs; id_rt = rt; id_wa = wa; id_alu_ctrl = op;
        id_alu_src = asrc; id_reg_write = 1; id_mem_write = 0; id_mem_to_reg = load;
        id_rs_data = 32'h1000_0000 | 32'(rs); id_rt_data = 32'h2000_0000 | 32'(rt);
        id_imm = 32'h0000_0100;
    endtask

    task automatic drive_rand();
        id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_wa = 5'($urandom_range(0, 7)); id_alu_ctrl = 3'($urandom_range(0, 3));
        id_alu_src = 1'($urandom); id_reg_write = 1'($urandom); id_mem_write = 1'($urandom);
        id_mem_to_reg = ($urandom_range(0, 9) < 3);
        flush = ($urandom_range(0, 9) == 0);
        mem_reg_write = 1'($urandom); mem_wa = 5'($urandom_range(0, 7)); mem_wd = $urandom;
        wb_reg_write = 1'($urandom); wb_wa = 5'($urandom_range(0, 7)); wb_wd = $urandom;
    endtask

    initial begin
        m = bubble();
        rst_n = 0; flush = 0;
        set_id(32'h0, 0, 0, 0, 3'd0, 0, 0);
        quiet_fwd();
        #12;
        chk("reset_valid", 32'(ex_valid), 32'h0);
        chk("reset_src_a", src_a, 32'h0);
        chk("reset_stall", 32'(stall_req), 32'h0);
        check_model();
        @(negedge clk);
        rst_n = 1;
        #1 check_model();

        // EX/MEM forward beats MEM/WB on the same register.
        set_id(32'h40, 8, 3, 4, 3'd0, 0, 0);
        tick();
        mem_reg_write = 1; mem_wa = 8; mem_wd = 32'h1234;
        wb_reg_write = 1; wb_wa = 8; wb_wd = 32'h5555;
        #1 chk("fwd_mem_a", src_a, 32'h0000_1234);
        check_model();

        // MEM/WB forward to rt.
        quiet_fwd();
        set_id(32'h44, 1, 9, 4, 3'd1, 0, 0);
        tick();
        wb_reg_write = 1; wb_wa = 9; wb_wd = 32'hABCD;
        #1 chk("fwd_wb_b", src_b, 32'h0000_ABCD);
        check_model();

        // $0 never forwards.
        quiet_fwd();
        set_id(32'h48, 1, 0, 4, 3'd0, 0, 0);
        tick();
        wb_reg_write = 1; wb_wa = 0; wb_wd = 32'hABCD;
        #1 chk("zero_guard_b", src_b, 32'h2000_0000);
        check_model();

        // Immediate select while store data still forwards.
        quiet_fwd();
        set_id(32'h4C, 1, 9, 4, 3'd3, 1, 0);
        id_imm = 32'h0000_FFFF;
        tick();
        wb_reg_write = 1; wb_wa = 9; wb_wd = 32'h77;
        #1 chk("imm_src_b", src_b, 32'h0000_FFFF);
        chk("imm_store", ex_store_data, 32'h77);
        chk("imm_alu_ctrl", 32'(alu_ctrl), 32'h3);
        check_model();

        // Load-use: one bubble, then MEM/WB supplies the loaded value.
        quiet_fwd();
        set_id(32'h50, 2, 3, 5, 3'd0, 1, 1);
        tick();
        set_id(32'h54, 5, 1, 6, 3'd0, 0, 0);
        #1 chk("lu_stall", 32'(stall_req), 32'h1);
        check_model();
        tick();
        #1 chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_stall_clear", 32'(stall_req), 32'h0);
        check_model();
        tick();
        wb_reg_write = 1; wb_wa = 5; wb_wd = 32'h42;
        #1 chk("lu_fwd_a", src_a, 32'h42);
        chk("lu_pc", ex_pc, 32'h54);
        check_model();

        // Flush coinciding with a load-use stall: single bubble, next instruction normal.
        quiet_fwd();
        set_id(32'h58, 2, 3, 5, 3'd0, 1, 1);
        tick();
        set_id(32'h5C, 5, 1, 6, 3'd0, 0, 0);
        flush = 1;
        #1 chk("fs_stall", 32'(stall_req), 32'h1);
        tick();
        flush = 0;
        set_id(32'h100, 1, 2, 7, 3'd2, 0, 0);
        #1 chk("fs_bubble", 32'(ex_valid), 32'h0);
        check_model();
        tick();
        #1 chk("fs_next_valid", 32'(ex_valid), 32'h1);
        chk("fs_next_pc", ex_pc, 32'h100);
        check_model();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            #1 check_model();
            tick();
        end

        // Asynchronous reset in the middle of a cycle with a valid instruction latched.
        quiet_fwd();
        flush = 0;
        set_id(32'h200, 1, 2, 3, 3'd1, 0, 0);
        tick();
        #1 chk("pre_rst_valid", 32'(ex_valid), 32'h1);
        #1 rst_n = 0;
        #1 chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_pc", ex_pc, 32'h0);
        chk("rst_stall", 32'(stall_req), 32'h0);
        m = bubble();
        check_model();
        @(negedge clk);
        rst_n = 1;
        tick();
        #1 chk("post_rst_pc", ex_pc, 32'h200);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
